// File: rtl/cv32e40p_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40p_pkg
// Shared types for the instruction-side OBI adapter.
//   instr_obi_state_e : adapter request state
//     TRANSPARENT - the prefetch request passes straight through to OBI
//     REGISTERED  - a request is stalled, so the address is held from a register
// -----------------------------------------------------------------------------
package cv32e40p_pkg;

  typedef enum logic [0:0] {
    TRANSPARENT = 1'b0,
    REGISTERED  = 1'b1
  } instr_obi_state_e;

endpackage : cv32e40p_pkg

// File: rtl/cv32e40p_instr_obi_adapter.sv
// -----------------------------------------------------------------------------
// cv32e40p_instr_obi_adapter
// Connects the prefetch controller's transaction interface to the core's
// instruction-side OBI master port. It does three things:
//   - turns trans_valid/trans_ready into OBI req/gnt
//   - keeps the OBI address stable while a request waits for its grant
//   - limits accepted-but-unanswered transactions to MAX_OUTSTANDING
// Responses go back to the prefetch controller and the fetch FIFO as resp_*.
//
// Configuration macro:
//   CV32E40P_INSTR_OBI_RESP_REG_EN - when defined, the response path is
//   registered (one cycle of latency). When undefined, responses pass through
//   combinationally.
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   trans_valid_i       transaction request from the prefetch controller
//   trans_ready_o       transaction accepted when valid && ready
//   trans_addr_i        transaction address (may change until accepted)
//   resp_valid_o        response valid (the consumer is always ready)
//   resp_rdata_o        response instruction word
//   resp_err_o          response bus error
//   obi_req_o/gnt_i     OBI address-phase handshake
//   obi_addr_o          OBI address
//   obi_rvalid_i        OBI response valid
//   obi_rdata_i/err_i   OBI response data / error
//   outstanding_o       count of granted transactions not yet answered
//   busy_o              transactions in flight or request pending
//   proto_err_o         sticky: rvalid arrived with nothing outstanding
// -----------------------------------------------------------------------------
module cv32e40p_instr_obi_adapter
  import cv32e40p_pkg::*;
#(
  parameter  int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trans_valid_i,
  output logic             trans_ready_o,
  input  logic [31:0]      trans_addr_i,
  output logic             resp_valid_o,
  output logic [31:0]      resp_rdata_o,
  output logic             resp_err_o,
  output logic             obi_req_o,
  input  logic             obi_gnt_i,
  output logic [31:0]      obi_addr_o,
  input  logic             obi_rvalid_i,
  input  logic [31:0]      obi_rdata_i,
  input  logic             obi_err_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             busy_o,
  output logic             proto_err_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  instr_obi_state_e state_q;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             proto_err_q;

  logic             space;
  logic             req_int;
  logic             ready_int;
  logic [31:0]      addr_int;
  logic             cnt_inc;
  logic             cnt_dec;
  logic             resp_pending;

  // A response arriving this cycle frees its slot immediately.
  assign space = (cnt_q < MAX_CNT) || obi_rvalid_i;

  // NOTE: every output of this block gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    req_int   = 1'b0;
    ready_int = 1'b0;
    addr_int  = trans_addr_i;
    case (state_q)
      TRANSPARENT: begin
        req_int   = trans_valid_i && space;
        ready_int = space;
        addr_int  = trans_addr_i;
      end
      REGISTERED: begin
        req_int   = 1'b1;
        ready_int = 1'b0;
        addr_int  = addr_q;
      end
      default: ;
    endcase
  end

  // Outputs go quiet while reset is asserted, even before the first clock edge.
  assign obi_req_o     = req_int && rst_n;
  assign trans_ready_o = ready_int && rst_n;
  assign obi_addr_o    = rst_n ? addr_int : 32'h0;

  // The address-phase state machine. Once a request has been issued without
  // a grant, it is committed: the address is held and new transactions are
  // blocked until the grant arrives.
  // NOTE: state registers use non-blocking assignments, so every flop in the
  // block samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TRANSPARENT;
      addr_q  <= 32'h0;
    end else begin
      case (state_q)
        TRANSPARENT: begin
          if (req_int && !obi_gnt_i) begin
            addr_q  <= trans_addr_i;
            state_q <= REGISTERED;
          end
        end
        REGISTERED: begin
          if (obi_gnt_i) begin
            state_q <= TRANSPARENT;
          end
        end
        default: state_q <= TRANSPARENT;
      endcase
    end
  end

  // Outstanding counter. A response with nothing outstanding does not
  // decrement; instead it flags a protocol error.
  assign cnt_inc = req_int && obi_gnt_i;
  assign cnt_dec = obi_rvalid_i && (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      case ({cnt_inc, cnt_dec})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (obi_rvalid_i && (cnt_q == '0)) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign outstanding_o = cnt_q;
  assign proto_err_o   = proto_err_q;

`ifdef CV32E40P_INSTR_OBI_RESP_REG_EN
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  // The counter has already dropped when the response sits in this register,
  // so the register's valid bit is what keeps busy_o asserted until delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= obi_rvalid_i;
      resp_rdata_q <= obi_rdata_i;
      resp_err_q   <= obi_err_i;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign resp_pending = resp_valid_q;
`else
  assign resp_valid_o = obi_rvalid_i;
  assign resp_rdata_o = obi_rdata_i;
  assign resp_err_o   = obi_err_i;
  assign resp_pending = 1'b0;
`endif

  assign busy_o = (cnt_q != '0) || obi_req_o || resp_pending;

endmodule : cv32e40p_instr_obi_adapter

// File: tb/tb_cv32e40p_instr_obi_adapter.sv
// -----------------------------------------------------------------------------
// tb_cv32e40p_instr_obi_adapter
// Directed bench for the instruction-side OBI adapter (MAX_OUTSTANDING = 4).
// Inputs change just after the falling edge. Combinational outputs are
// sampled 1 ns later, and registered state is sampled on the following
// falling edge.
// -----------------------------------------------------------------------------
module tb_cv32e40p_instr_obi_adapter;

  localparam int unsigned MAX_OUT = 4;
  localparam int unsigned CW      = $clog2(MAX_OUT + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          trans_valid;
  logic          trans_ready;
  logic [31:0]   trans_addr;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          obi_req;
  logic          obi_gnt;
  logic [31:0]   obi_addr;
  logic          obi_rvalid;
  logic [31:0]   obi_rdata;
  logic          obi_err;
  logic [CW-1:0] outstanding;
  logic          busy;
  logic          proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cv32e40p_instr_obi_adapter #(.MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .trans_valid_i (trans_valid),
    .trans_ready_o (trans_ready),
    .trans_addr_i  (trans_addr),
    .resp_valid_o  (resp_valid),
    .resp_rdata_o  (resp_rdata),
    .resp_err_o    (resp_err),
    .obi_req_o     (obi_req),
    .obi_gnt_i     (obi_gnt),
    .obi_addr_o    (obi_addr),
    .obi_rvalid_i  (obi_rvalid),
    .obi_rdata_i   (obi_rdata),
    .obi_err_i     (obi_err),
    .outstanding_o (outstanding),
    .busy_o        (busy),
    .proto_err_o   (proto_err)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Apply one cycle of inputs after the falling edge. Combinational outputs
  // are checked after the 1 ns settle delay.
  task automatic drive(input logic tv, input logic [31:0] ta, input logic gnt,
                       input logic rv, input logic [31:0] rd, input logic er);
    @(negedge clk);
    trans_valid = tv;
    trans_addr  = ta;
    obi_gnt     = gnt;
    obi_rvalid  = rv;
    obi_rdata   = rd;
    obi_err     = er;
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    trans_valid = 1'b1;
    trans_addr  = 32'h0000_0040;
    obi_gnt     = 1'b1;
    obi_rvalid  = 1'b0;
    obi_rdata   = 32'h0;
    obi_err     = 1'b0;
    #12;

    // Reset state: nothing is issued or accepted, even with trans_valid high.
    check("rst_req",   32'(obi_req), 0);
    check("rst_ready", 32'(trans_ready), 0);
    check("rst_addr",  obi_addr, 32'h0);
    check("rst_cnt",   32'(outstanding), 0);
    check("rst_perr",  32'(proto_err), 0);
    check("rst_busy",  32'(busy), 0);

    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;

    // Immediate grant at 0x100, answered on the next cycle.
    drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0);
    check("ig_req",   32'(obi_req), 1);
    check("ig_addr",  obi_addr, 32'h100);
    check("ig_ready", 32'(trans_ready), 1);
    check("ig_cnt0",  32'(outstanding), 0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    check("ig_cnt1",  32'(outstanding), 1);
`ifdef CV32E40P_INSTR_OBI_RESP_REG_EN
    check("ig_rv_lat", 32'(resp_valid), 0);
`else
    check("ig_rvalid", 32'(resp_valid), 1);
    check("ig_rdata",  resp_rdata, 32'hDEAD_BEEF);
`endif
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("ig_cnt2",  32'(outstanding), 0);
`ifdef CV32E40P_INSTR_OBI_RESP_REG_EN
    check("rr_rvalid", 32'(resp_valid), 1);
    check("rr_rdata",  resp_rdata, 32'hDEAD_BEEF);
    check("rr_busy",   32'(busy), 1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("rr_done",   32'(resp_valid), 0);
`endif
    check("ig_idle",  32'(busy), 0);

    // Stalled grant: the address holds at 0x200 while trans_addr moves.
    drive(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
    check("st_req0",   32'(obi_req), 1);
    check("st_addr0",  obi_addr, 32'h200);
    check("st_ready0", 32'(trans_ready), 1);
    drive(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
    check("st_addr1",  obi_addr, 32'h200);
    check("st_ready1", 32'(trans_ready), 0);
    check("st_req1",   32'(obi_req), 1);
    drive(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
    check("st_addr2",  obi_addr, 32'h200);
    check("st_cnt2",   32'(outstanding), 0);
    drive(1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 1'b0);
    check("st_addr3",  obi_addr, 32'h200);
    check("st_ready3", 32'(trans_ready), 0);
    drive(1'b0, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
    check("st_cnt4",   32'(outstanding), 1);
    check("st_transp", obi_addr, 32'h300);
    check("st_ready4", 32'(trans_ready), 1);
    check("st_req4",   32'(obi_req), 0);

    // Fill to MAX_OUTSTANDING with three more immediate grants (1 -> 4).
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h400 + 32'(i * 4), 1'b1, 1'b0, 32'h0, 1'b0);
    end
    drive(1'b1, 32'h500, 1'b1, 1'b0, 32'h0, 1'b0);
    check("fu_cnt",   32'(outstanding), 4);
    check("fu_req",   32'(obi_req), 0);
    check("fu_ready", 32'(trans_ready), 0);
    check("fu_busy",  32'(busy), 1);
    // A response in the same cycle frees a slot for a new request.
    obi_rvalid = 1'b1;
    obi_rdata  = 32'h1111_2222;
    #1;
    check("fu_req_rv",   32'(obi_req), 1);
    check("fu_ready_rv", 32'(trans_ready), 1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h3333_4444, 1'b1);
    check("fu_cnt_hold", 32'(outstanding), 4);
`ifndef CV32E40P_INSTR_OBI_RESP_REG_EN
    check("er_resp_err", 32'(resp_err), 1);
`endif
    // Drain the remaining three responses (3 -> 0).
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("dr_cnt",  32'(outstanding), 0);
    check("dr_perr", 32'(proto_err), 0);

    // rvalid with nothing outstanding: flag is sticky, counter stays at 0.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_AAAA, 1'b0);
`ifndef CV32E40P_INSTR_OBI_RESP_REG_EN
    check("pe_fwd", 32'(resp_valid), 1);
`endif
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("pe_set",  32'(proto_err), 1);
    check("pe_cnt",  32'(outstanding), 0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("pe_stky", 32'(proto_err), 1);

    // Async reset while REGISTERED with two transactions outstanding.
    drive(1'b1, 32'h600, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 32'h604, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 32'h800, 1'b0, 1'b0, 32'h0, 1'b0);
    check("ar_cnt2", 32'(outstanding), 2);
    check("ar_hold", obi_addr, 32'h700);
    check("ar_req1", 32'(obi_req), 1);
    rst_n = 1'b0;
    #1;
    check("ar_req0", 32'(obi_req), 0);
    check("ar_cnt0", 32'(outstanding), 0);
    check("ar_perr", 32'(proto_err), 0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, 32'h900, 1'b1, 1'b0, 32'h0, 1'b0);
    check("ar_new_req",  32'(obi_req), 1);
    check("ar_new_addr", obi_addr, 32'h900);
    check("ar_new_rdy",  32'(trans_ready), 1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("ar_new_cnt",  32'(outstanding), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cv32e40p_instr_obi_adapter
